core_run_ctrl: RTL and testbench
================================

CORE_RUN_CTRL -- requirements
Module: core_run_ctrl

Interface
REQ-001 Parameter: MAX_CYCLES, 16'd4096, RUN-phase cycle budget before timeout; legal range 2..65535.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 start  input  1  host request to begin a load/run sequence; level sampled each cycle.
REQ-005 ld_valid  input  1  host preload word valid.
REQ-006 ld_addr  input  8  host preload data-memory address.
REQ-007 ld_data  input  8  host preload data word.
REQ-008 ld_last  input  1  qualifies the final preload word; meaningful only with ld_valid.
REQ-009 ld_ready  output  1  controller accepts a preload word this cycle.
REQ-010 core_mem_we, core_mem_addr, core_mem_wdata  input  1/8/8  processor data-memory write port.
REQ-011 core_done  input  1  processor halt indication (PC reached end of program).
REQ-012 core_reset  output  1  holds processor (PC, regFile) in reset when high.
REQ-013 mem_we, mem_addr, mem_wdata  output  1/8/8  arbitrated data-memory write port.
REQ-014 ld_count  output  8  preload words accepted in current sequence.
REQ-015 cycle_cnt  output  16  cycles spent in RUN for current sequence.
REQ-016 busy  output  1  high in LOAD or RUN.
REQ-017 done  output  1  high in FINISH.
REQ-018 error  output  1  high in FINISH when sequence ended by timeout.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, RUN, FINISH; one-hot or binary is implementation choice.
REQ-020 IDLE: core_reset=1, ld_ready=0, mem_we=0; start=1 -> LOAD next cycle.
REQ-021 Entry to LOAD (from IDLE or FINISH) SHALL clear ld_count, cycle_cnt and error on the same edge.
REQ-022 LOAD: core_reset=1, ld_ready=1; mem_we=ld_valid, mem_addr=ld_addr, mem_wdata=ld_data, combinational, zero latency.
REQ-023 LOAD: each cycle with ld_valid=1 SHALL increment ld_count by 1, wrapping 255 -> 0.
REQ-024 LOAD: ld_valid=1 and ld_last=1 -> RUN next cycle; that word is still written.
REQ-025 LOAD: start SHALL be ignored; ld_last without ld_valid SHALL be ignored.
REQ-026 RUN: core_reset=0, ld_ready=0; mem_we/addr/wdata SHALL pass core_mem_* unmodified; host ld_* ignored.
REQ-027 RUN: cycle_cnt SHALL increment by 1 every cycle, first RUN cycle reads 0, saturating at 16'hFFFF.
REQ-028 RUN: core_done=1 -> FINISH next cycle with error=0.
REQ-029 RUN: core_done=0 and cycle_cnt==MAX_CYCLES-1 -> FINISH next cycle with error=1.
REQ-030 RUN: core_done=1 and timeout condition in same cycle -> FINISH with error=0 (done wins).
REQ-031 FINISH: core_reset=1, mem_we=0, ld_ready=0, done=1; ld_count, cycle_cnt, error held stable.
REQ-032 FINISH: start=1 -> LOAD next cycle; otherwise remain in FINISH.
REQ-033 busy SHALL equal (state==LOAD or state==RUN); all outputs other than the combinational mem/ld_ready paths SHALL be registered state decodes.

Reset
REQ-034 reset=1 SHALL force IDLE asynchronously, regardless of current state, including mid-LOAD or mid-RUN.
REQ-035 Reset values: core_reset=1, ld_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, ld_count=0, cycle_cnt=0, busy=0, done=0, error=0.
REQ-036 After reset release, no transition SHALL occur until start=1 is sampled on a rising edge.

Verification
REQ-037 Normal: start 1 cycle; preload 3 words (0x10<-0xAA, 0x11<-0xBB, 0x12<-0xCC, last on third) -> mem_we pulses with matching addr/data, ld_count=3, RUN entered next cycle with core_reset=0.
REQ-038 Completion: in RUN assert core_done on 20th RUN cycle -> FINISH, done=1, error=0, cycle_cnt=19 held, core_reset=1.
REQ-039 Timeout: MAX_CYCLES=8, core_done never -> FINISH after 8 RUN cycles, error=1, cycle_cnt=7.
REQ-040 Tie: MAX_CYCLES=8, core_done=1 on 8th RUN cycle -> FINISH with error=0.
REQ-041 Arbitration: in RUN drive ld_valid=1 with ld_addr=0x05 and core_mem_we=1, core_mem_addr=0x40 -> mem_addr=0x40, ld_ready=0; in LOAD core_mem_we=1 -> mem_we follows ld_valid only.
REQ-042 Async reset mid-RUN between clock edges -> outputs take REQ-035 values immediately; restart via start yields ld_count=0, cycle_cnt=0.

Source files
------------

// File: rtl/core_run_ctrl.sv
// Load/run sequencer for a small processor core: preloads data memory from the host,
// releases the core, and stops it on completion or when the cycle budget runs out.
//
// state  | meaning
// IDLE   | core held in reset, waiting for start
// LOAD   | host preload words written to data memory, core held in reset
// RUN    | core released, owns the data-memory write port, cycles counted
// FINISH | core held in reset, result flags and counters frozen until restart
module core_run_ctrl #(
    parameter logic [15:0] MAX_CYCLES = 16'd4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       ld_valid,
    input  logic [7:0] ld_addr,
    input  logic [7:0] ld_data,
    input  logic       ld_last,
    output logic       ld_ready,
    input  logic       core_mem_we,
    input  logic [7:0] core_mem_addr,
    input  logic [7:0] core_mem_wdata,
    input  logic       core_done,
    output logic       core_reset,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic [7:0] ld_count,
    output logic [15:0] cycle_cnt,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } ctrlState_t;

    ctrlState_t state;
    ctrlState_t nextState;
    logic       enterLoad;
    logic       timeout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        enterLoad = 1'b0;
        timeout   = 1'b0;
        ld_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 8'h00;
        mem_wdata = 8'h00;
        case (state)
            IDLE: begin
                if (start) begin
                    nextState = LOAD;
                    enterLoad = 1'b1;
                end
            end
            LOAD: begin
                ld_ready  = 1'b1;
                mem_we    = ld_valid;
                mem_addr  = ld_addr;
                mem_wdata = ld_data;
                if (ld_valid && ld_last) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                mem_we    = core_mem_we;
                mem_addr  = core_mem_addr;
                mem_wdata = core_mem_wdata;
                // A halt in the budget's final cycle counts as a clean finish.
                if (core_done) begin
                    nextState = FINISH;
                end else if (cycle_cnt == MAX_CYCLES - 16'd1) begin
                    nextState = FINISH;
                    timeout   = 1'b1;
                end
            end
            FINISH: begin
                if (start) begin
                    nextState = LOAD;
                    enterLoad = 1'b1;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Status outputs are flops loaded from the next state so they never glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_reset <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            ld_count   <= 8'h00;
            cycle_cnt  <= 16'h0000;
        end else begin
            core_reset <= (nextState != RUN);
            busy       <= (nextState == LOAD) || (nextState == RUN);
            done       <= (nextState == FINISH);
            if (enterLoad) begin
                ld_count  <= 8'h00;
                cycle_cnt <= 16'h0000;
                error     <= 1'b0;
            end else begin
                if (state == LOAD && ld_valid) begin
                    ld_count <= ld_count + 8'd1;
                end
                // The exit cycle is not counted, so FINISH reports the index of the last RUN cycle.
                if (state == RUN && nextState == RUN && cycle_cnt != 16'hFFFF) begin
                    cycle_cnt <= cycle_cnt + 16'd1;
                end
                if (timeout) begin
                    error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: two instances (default budget and budget of 8) share one stimulus
// stream and are compared against a cycle-level behavioural model plus directed vectors.
module tb_core_run_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, ld_valid, ld_last, core_mem_we, core_done;
    logic [7:0] ld_addr, ld_data, core_mem_addr, core_mem_wdata;

    logic        ldReady[2], coreReset[2], memWe[2], busyO[2], doneO[2], errorO[2];
    logic [7:0]  memAddr[2], memWdata[2], ldCount[2];
    logic [15:0] cycleCnt[2];

    core_run_ctrl dutA (
        .clk(clk), .reset(reset), .start(start), .ld_valid(ld_valid), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ldReady[0]), .core_mem_we(core_mem_we),
        .core_mem_addr(core_mem_addr), .core_mem_wdata(core_mem_wdata), .core_done(core_done),
        .core_reset(coreReset[0]), .mem_we(memWe[0]), .mem_addr(memAddr[0]),
        .mem_wdata(memWdata[0]), .ld_count(ldCount[0]), .cycle_cnt(cycleCnt[0]),
        .busy(busyO[0]), .done(doneO[0]), .error(errorO[0])
    );

    core_run_ctrl #(.MAX_CYCLES(16'd8)) dutB (
        .clk(clk), .reset(reset), .start(start), .ld_valid(ld_valid), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ldReady[1]), .core_mem_we(core_mem_we),
        .core_mem_addr(core_mem_addr), .core_mem_wdata(core_mem_wdata), .core_done(core_done),
        .core_reset(coreReset[1]), .mem_we(memWe[1]), .mem_addr(memAddr[1]),
        .mem_wdata(memWdata[1]), .ld_count(ldCount[1]), .cycle_cnt(cycleCnt[1]),
        .busy(busyO[1]), .done(doneO[1]), .error(errorO[1])
    );

    int nVec = 0;
    int nMis = 0;
    string pfx[2] = '{"A", "B"};

    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_RUN  = 2;
    localparam int PH_FIN  = 3;
    int mPh[2], mLd[2], mCyc[2], mErr[2];
    int maxC[2] = '{4096, 8};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            mPh[i] = PH_IDLE; mLd[i] = 0; mCyc[i] = 0; mErr[i] = 0;
        end
    endtask

    task automatic enterLoad(input int i);
        mPh[i] = PH_LOAD; mLd[i] = 0; mCyc[i] = 0; mErr[i] = 0;
    endtask

    task automatic modelStep();
        if (reset) begin
            modelReset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                case (mPh[i])
                    PH_IDLE: if (start) enterLoad(i);
                    PH_LOAD: if (ld_valid) begin
                        mLd[i] = (mLd[i] + 1) % 256;
                        if (ld_last) mPh[i] = PH_RUN;
                    end
                    PH_RUN: begin
                        if (core_done) mPh[i] = PH_FIN;
                        else if (mCyc[i] == maxC[i] - 1) begin
                            mPh[i] = PH_FIN; mErr[i] = 1;
                        end else if (mCyc[i] < 65535) mCyc[i] = mCyc[i] + 1;
                    end
                    default: if (start) enterLoad(i);
                endcase
            end
        end
    endtask

    task automatic checkAll();
        int eWe, eAddr, eData;
        if (reset) modelReset();
        for (int i = 0; i < 2; i++) begin
            eWe = 0; eAddr = 0; eData = 0;
            if (mPh[i] == PH_LOAD) begin
                eWe = int'(ld_valid); eAddr = int'(ld_addr); eData = int'(ld_data);
            end else if (mPh[i] == PH_RUN) begin
                eWe = int'(core_mem_we); eAddr = int'(core_mem_addr); eData = int'(core_mem_wdata);
            end
            chk($sformatf("%s mem_we", pfx[i]), 32'(memWe[i]), eWe);
            chk($sformatf("%s mem_addr", pfx[i]), 32'(memAddr[i]), eAddr);
            chk($sformatf("%s mem_wdata", pfx[i]), 32'(memWdata[i]), eData);
            chk($sformatf("%s ld_ready", pfx[i]), 32'(ldReady[i]), 32'(mPh[i] == PH_LOAD));
            chk($sformatf("%s core_reset", pfx[i]), 32'(coreReset[i]), 32'(mPh[i] != PH_RUN));
            chk($sformatf("%s busy", pfx[i]), 32'(busyO[i]),
                32'(mPh[i] == PH_LOAD || mPh[i] == PH_RUN));
            chk($sformatf("%s done", pfx[i]), 32'(doneO[i]), 32'(mPh[i] == PH_FIN));
            chk($sformatf("%s error", pfx[i]), 32'(errorO[i]), mErr[i]);
            chk($sformatf("%s ld_count", pfx[i]), 32'(ldCount[i]), mLd[i]);
            chk($sformatf("%s cycle_cnt", pfx[i]), 32'(cycleCnt[i]), mCyc[i]);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        checkAll();
    endtask

    task automatic advance();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic quietInputs();
        start = 0; ld_valid = 0; ld_last = 0; ld_addr = 0; ld_data = 0;
        core_mem_we = 0; core_mem_addr = 0; core_mem_wdata = 0; core_done = 0;
    endtask

    // Start from IDLE/FINISH, preload one word, then run with core_done pulsed on RUN cycle doneAt.
    task automatic runSeq(input int doneAt);
        start = 1; settle(); advance(); start = 0;
        ld_valid = 1; ld_last = 1; ld_addr = 8'h30; ld_data = 8'h5A;
        settle();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s restart ld_count", pfx[i]), 32'(ldCount[i]), 0);
            chk($sformatf("%s restart cycle_cnt", pfx[i]), 32'(cycleCnt[i]), 0);
            chk($sformatf("%s restart error", pfx[i]), 32'(errorO[i]), 0);
        end
        advance(); ld_valid = 0; ld_last = 0;
        for (int k = 1; k <= doneAt; k++) begin
            core_done = (k == doneAt);
            settle(); advance();
        end
        core_done = 0;
    endtask

    typedef struct {
        logic st, lv; logic [7:0] la, ld; logic ll, cw; logic [7:0] ca, cd; logic cdn;
        logic eWe; logic [7:0] eAddr, eData; logic eRdy, eCr; logic [7:0] eLd;
        logic [15:0] eCyc; logic eBusy, eDone;
    } vec_t;

    vec_t tbl[9];

    initial begin
        //          st lv la     ld     ll cw ca     cd     cdn eWe eAddr  eData  rdy cr eLd    eCyc    busy done
        tbl[0] = '{1, 0, 8'h00, 8'h00, 0, 1, 8'h40, 8'h99, 0,  0, 8'h00, 8'h00, 0, 1, 8'd0, 16'd0, 0, 0};
        tbl[1] = '{1, 1, 8'h10, 8'hAA, 0, 1, 8'h40, 8'h99, 0,  1, 8'h10, 8'hAA, 1, 1, 8'd0, 16'd0, 1, 0};
        tbl[2] = '{0, 0, 8'h20, 8'h55, 1, 0, 8'h00, 8'h00, 0,  0, 8'h20, 8'h55, 1, 1, 8'd1, 16'd0, 1, 0};
        tbl[3] = '{0, 1, 8'h11, 8'hBB, 0, 1, 8'h40, 8'h01, 0,  1, 8'h11, 8'hBB, 1, 1, 8'd1, 16'd0, 1, 0};
        tbl[4] = '{0, 1, 8'h12, 8'hCC, 1, 0, 8'h00, 8'h00, 0,  1, 8'h12, 8'hCC, 1, 1, 8'd2, 16'd0, 1, 0};
        tbl[5] = '{0, 1, 8'h05, 8'hEE, 1, 1, 8'h40, 8'h77, 0,  1, 8'h40, 8'h77, 0, 0, 8'd3, 16'd0, 1, 0};
        tbl[6] = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h41, 8'h12, 0,  0, 8'h41, 8'h12, 0, 0, 8'd3, 16'd1, 1, 0};
        tbl[7] = '{0, 0, 8'h00, 8'h00, 0, 1, 8'h42, 8'h34, 1,  1, 8'h42, 8'h34, 0, 0, 8'd3, 16'd2, 1, 0};
        tbl[8] = '{0, 1, 8'h07, 8'h08, 0, 1, 8'h43, 8'h56, 0,  0, 8'h00, 8'h00, 0, 1, 8'd3, 16'd2, 0, 1};

        quietInputs();
        reset = 1;
        settle(); advance();
        reset = 0;

        foreach (tbl[n]) begin
            start = tbl[n].st; ld_valid = tbl[n].lv; ld_addr = tbl[n].la; ld_data = tbl[n].ld;
            ld_last = tbl[n].ll; core_mem_we = tbl[n].cw; core_mem_addr = tbl[n].ca;
            core_mem_wdata = tbl[n].cd; core_done = tbl[n].cdn;
            settle();
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("vec%0d %s mem_we", n, pfx[i]), 32'(memWe[i]), 32'(tbl[n].eWe));
                chk($sformatf("vec%0d %s mem_addr", n, pfx[i]), 32'(memAddr[i]), 32'(tbl[n].eAddr));
                chk($sformatf("vec%0d %s mem_wdata", n, pfx[i]), 32'(memWdata[i]), 32'(tbl[n].eData));
                chk($sformatf("vec%0d %s ld_ready", n, pfx[i]), 32'(ldReady[i]), 32'(tbl[n].eRdy));
                chk($sformatf("vec%0d %s core_reset", n, pfx[i]), 32'(coreReset[i]), 32'(tbl[n].eCr));
                chk($sformatf("vec%0d %s ld_count", n, pfx[i]), 32'(ldCount[i]), 32'(tbl[n].eLd));
                chk($sformatf("vec%0d %s cycle_cnt", n, pfx[i]), 32'(cycleCnt[i]), 32'(tbl[n].eCyc));
                chk($sformatf("vec%0d %s busy", n, pfx[i]), 32'(busyO[i]), 32'(tbl[n].eBusy));
                chk($sformatf("vec%0d %s done", n, pfx[i]), 32'(doneO[i]), 32'(tbl[n].eDone));
            end
            advance();
        end
        quietInputs();

        // Halt on RUN cycle 20: A completes, B (budget 8) has already timed out.
        runSeq(20);
        settle();
        chk("cmpl A done", 32'(doneO[0]), 1);
        chk("cmpl A error", 32'(errorO[0]), 0);
        chk("cmpl A cycle_cnt", 32'(cycleCnt[0]), 19);
        chk("cmpl A core_reset", 32'(coreReset[0]), 1);
        chk("tmo B done", 32'(doneO[1]), 1);
        chk("tmo B error", 32'(errorO[1]), 1);
        chk("tmo B cycle_cnt", 32'(cycleCnt[1]), 7);
        advance();
        settle(); advance();
        chk("hold A cycle_cnt", 32'(cycleCnt[0]), 19);

        // Halt coinciding with the last budgeted cycle of B: done wins.
        runSeq(8);
        settle();
        chk("tie B done", 32'(doneO[1]), 1);
        chk("tie B error", 32'(errorO[1]), 0);
        chk("tie B cycle_cnt", 32'(cycleCnt[1]), 7);
        chk("tie A error", 32'(errorO[0]), 0);
        advance();

        // Asynchronous reset between edges while running.
        start = 1; settle(); advance(); start = 0;
        ld_valid = 1; ld_last = 1; ld_addr = 8'h01; ld_data = 8'h02;
        settle(); advance(); ld_valid = 0; ld_last = 0;
        core_mem_we = 1; core_mem_addr = 8'h40; core_mem_wdata = 8'h66;
        for (int k = 0; k < 4; k++) begin
            settle(); advance();
        end
        #2 reset = 1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("arst %s core_reset", pfx[i]), 32'(coreReset[i]), 1);
            chk($sformatf("arst %s ld_ready", pfx[i]), 32'(ldReady[i]), 0);
            chk($sformatf("arst %s mem_we", pfx[i]), 32'(memWe[i]), 0);
            chk($sformatf("arst %s mem_addr", pfx[i]), 32'(memAddr[i]), 0);
            chk($sformatf("arst %s mem_wdata", pfx[i]), 32'(memWdata[i]), 0);
            chk($sformatf("arst %s ld_count", pfx[i]), 32'(ldCount[i]), 0);
            chk($sformatf("arst %s cycle_cnt", pfx[i]), 32'(cycleCnt[i]), 0);
            chk($sformatf("arst %s busy", pfx[i]), 32'(busyO[i]), 0);
            chk($sformatf("arst %s done", pfx[i]), 32'(doneO[i]), 0);
            chk($sformatf("arst %s error", pfx[i]), 32'(errorO[i]), 0);
        end
        modelReset();
        settle(); advance();
        reset = 0;
        for (int k = 0; k < 3; k++) begin
            settle(); advance();
        end
        start = 1; settle(); advance(); start = 0;
        settle();
        chk("restart A ld_count", 32'(ldCount[0]), 0);
        chk("restart A cycle_cnt", 32'(cycleCnt[0]), 0);
        chk("restart A busy", 32'(busyO[0]), 1);
        advance();
        quietInputs();

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(199) == 0);
            start = ($urandom_range(7) == 0);
            ld_valid = 1'($urandom_range(1));
            ld_last = ($urandom_range(3) == 0);
            ld_addr = 8'($urandom); ld_data = 8'($urandom);
            core_mem_we = 1'($urandom_range(1));
            core_mem_addr = 8'($urandom); core_mem_wdata = 8'($urandom);
            core_done = ($urandom_range(23) == 0);
            settle(); advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
